// File: rtl/wbu_pkg.sv
// Shared definitions for the wbu UART transmitter and its matching receiver.
package wbu_pkg;

  // Transmitter state encoding (plain constants for legacy tool flows).
  typedef logic [2:0] tx_state_t;

  localparam logic [2:0] TX_IDLE  = 3'd0;
  localparam logic [2:0] TX_START = 3'd1;
  localparam logic [2:0] TX_DATA  = 3'd2;
  localparam logic [2:0] TX_STOP  = 3'd3;
  localparam logic [2:0] TX_BREAK = 3'd4;

  // Payload bits per character (8N1 framing).
  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/wbu_txuart_if.sv
// Byte strobe / busy handshake between the bus/console multiplexer and the
// UART transmitter. The multiplexer is the master; the transmitter the slave.
interface wbu_txuart_if;
  logic                                stb;
  logic [wbu_pkg::UART_DATA_BITS-1:0]  data;
  logic                                busy;

  modport master (output stb, output data, input busy);
  modport slave  (input stb, input data, output busy);
endinterface

// File: rtl/wbu_baudcnt.sv
// Loadable baud down-counter with registered zero and one flags.
// Shared between the transmitter and the receiver.
module wbu_baudcnt #(
  parameter int W = 24
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero,
  output logic         o_one
);

  localparam logic [W-1:0] ONE_V = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;
  logic         zero_q, one_q;

  // Next count: a load wins over a decrement; decrementing stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE_V;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register; flags are registered from the next count so they always
  // describe the value currently held.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
      one_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
      one_q  <= (cnt_d == ONE_V);
    end
  end

  assign o_zero = zero_q;
  assign o_one  = one_q;

endmodule

// File: rtl/wbu_txuart.sv
// 8N1 UART transmitter fed by the bus/console multiplexer's strobe/busy
// handshake. The divisor is a runtime input captured at each accept; a break
// request holds the line low while the transmitter is idle.
module wbu_txuart
  import wbu_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD_W = 24,
  parameter int MIN_DIV           = 2
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic [CLOCKS_PER_BAUD_W-1:0] i_baud_div,
  wbu_txuart_if.slave                  bus,
  input  logic                         i_break,
  output logic                         o_uart_tx,
  output logic                         o_idle
);

  localparam int W = CLOCKS_PER_BAUD_W;
  localparam logic [W-1:0] MIN_DIV_V = W'(MIN_DIV);
  localparam logic [W-1:0] ONE_V     = {{(W-1){1'b0}}, 1'b1};

  // Clamp is done at the full divisor width so 0 and 1 both map to MIN_DIV.
  function automatic logic [W-1:0] clamp_div(input logic [W-1:0] req);
    if (req < MIN_DIV_V) begin
      return MIN_DIV_V;
    end else begin
      return req;
    end
  endfunction

  tx_state_t    state_q, state_d;
  logic         tx_q, tx_d;
  logic         busy_q, busy_d;
  logic         idle_q, idle_d;
  logic [7:0]   shift_q, shift_d;
  logic [2:0]   bitcnt_q, bitcnt_d;
  logic [W-1:0] div_q, div_d;

  logic         cnt_load_s, cnt_dec_s, cnt_zero_s, cnt_one_s;
  logic [W-1:0] cnt_val_s;
  logic [W-1:0] req_div_s;

  assign req_div_s = clamp_div(i_baud_div);

  wbu_baudcnt #(.W(W)) u_baudcnt (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_load     (cnt_load_s),
    .i_load_val (cnt_val_s),
    .i_dec      (cnt_dec_s),
    .o_zero     (cnt_zero_s),
    .o_one      (cnt_one_s)
  );

  // Frame sequencing: every bit (start, data, stop) lasts div clocks, counted
  // by reloading the baud counter with div-1 and stepping on each zero.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    div_d      = div_q;
    cnt_load_s = 1'b0;
    cnt_val_s  = div_q - ONE_V;
    cnt_dec_s  = 1'b0;

    case (state_q)
      TX_IDLE: begin
        if (i_break) begin
          // Break has priority over a pending byte.
          state_d = TX_BREAK;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end else if (bus.stb) begin
          shift_d    = bus.data;
          div_d      = req_div_s;
          cnt_load_s = 1'b1;
          cnt_val_s  = req_div_s - ONE_V;
          busy_d     = 1'b1;
          tx_d       = 1'b0;
          state_d    = TX_START;
        end else begin
          tx_d   = 1'b1;
          busy_d = 1'b0;
        end
      end

      TX_START: begin
        if (cnt_zero_s) begin
          tx_d       = shift_q[0];
          shift_d    = {1'b0, shift_q[7:1]};
          bitcnt_d   = 3'(UART_DATA_BITS - 1);
          cnt_load_s = 1'b1;
          state_d    = TX_DATA;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end

      TX_DATA: begin
        if (!cnt_zero_s) begin
          cnt_dec_s = 1'b1;
        end else if (bitcnt_q != 3'd0) begin
          tx_d       = shift_q[0];
          shift_d    = {1'b0, shift_q[7:1]};
          bitcnt_d   = bitcnt_q - 3'd1;
          cnt_load_s = 1'b1;
        end else begin
          tx_d       = 1'b1;
          cnt_load_s = 1'b1;
          state_d    = TX_STOP;
        end
      end

      TX_STOP: begin
        if (!cnt_zero_s) begin
          cnt_dec_s = 1'b1;
          // Drop busy one clock early so a waiting byte lands with no gap.
          if (cnt_one_s) begin
            busy_d = 1'b0;
          end else begin
            busy_d = busy_q;
          end
        end else if (bus.stb && !busy_q) begin
          shift_d    = bus.data;
          div_d      = req_div_s;
          cnt_load_s = 1'b1;
          cnt_val_s  = req_div_s - ONE_V;
          busy_d     = 1'b1;
          tx_d       = 1'b0;
          state_d    = TX_START;
        end else begin
          state_d = TX_IDLE;
        end
      end

      TX_BREAK: begin
        if (i_break) begin
          tx_d   = 1'b0;
          busy_d = 1'b1;
        end else begin
          // Release: one full idle bit (div clocks) before the next byte.
          tx_d       = 1'b1;
          cnt_load_s = 1'b1;
          state_d    = TX_STOP;
        end
      end

      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    idle_d = (state_d == TX_IDLE) && !i_break;
  end

  // State and output registers; line idles high out of reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= TX_IDLE;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      idle_q   <= 1'b1;
      shift_q  <= 8'h00;
      bitcnt_q <= 3'd0;
      div_q    <= MIN_DIV_V;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      idle_q   <= idle_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      div_q    <= div_d;
    end
  end

  assign o_uart_tx = tx_q;
  assign o_idle    = idle_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_wbu_txuart.sv
// Self-checking bench for wbu_txuart: table of single-byte frames, hand
// sequences for reset/break/back-to-back, and random frame bursts checked
// against a bit-level line model.
module tb_wbu_txuart;

  localparam int W = 24;

  logic         clk;
  logic         rst_n;
  logic         brk;
  logic         tx;
  logic         idle;
  logic [W-1:0] baud;

  wbu_txuart_if bus_if ();

  wbu_txuart #(.CLOCKS_PER_BAUD_W(W), .MIN_DIV(2)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_baud_div (baud),
    .bus        (bus_if),
    .i_break    (brk),
    .o_uart_tx  (tx),
    .o_idle     (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Frames queued for the next send_seq call.
  logic [7:0]   q_b[$];
  logic [W-1:0] q_d[$];
  int           q_bc[$];

  typedef struct {
    logic [7:0]   data;
    logic [W-1:0] div_in;
    int           exp_bit_clks;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int eff_div(input logic [W-1:0] d);
    return (d < 24'd2) ? 2 : int'(d);
  endfunction

  task automatic add_frame(input logic [7:0] b, input logic [W-1:0] d, input int bc);
    q_b.push_back(b);
    q_d.push_back(d);
    q_bc.push_back(bc);
  endtask

  task automatic clear_frames();
    q_b.delete();
    q_d.delete();
    q_bc.delete();
  endtask

  // Holds i_stb while the queued bytes are taken one after another, records
  // the line and busy after each accept, and compares with the expected
  // 8N1 waveform. pre_hi counts high line clocks before the first accept.
  task automatic send_seq(input string nm, output int pre_hi);
    logic       exp_tx[$];
    logic       exp_bz[$];
    logic       got_tx[$];
    logic       got_bz[$];
    logic [9:0] frame;
    int         n, since, cyc, limit, bad;
    logic       started, acc_next;

    for (int f = 0; f < q_b.size(); f++) begin
      frame = {1'b1, q_b[f], 1'b0};
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c < q_bc[f]; c++) begin
          exp_tx.push_back(frame[k]);
          exp_bz.push_back(!((k == 9) && (c == q_bc[f] - 1)));
        end
      end
    end
    repeat (2) begin
      exp_tx.push_back(1'b1);
      exp_bz.push_back(1'b0);
    end

    bus_if.stb  = 1'b1;
    bus_if.data = q_b[0];
    baud        = q_d[0];
    n = 0; since = 0; cyc = 0; pre_hi = 0; started = 1'b0;
    limit    = exp_tx.size() + 64;
    acc_next = !bus_if.busy && !brk;

    while ((got_tx.size() < exp_tx.size()) && (cyc < limit)) begin
      @(negedge clk);
      cyc++;
      if (acc_next) begin
        started = 1'b1;
        since   = 0;
        n++;
        if (n < q_b.size()) bus_if.data = q_b[n];
        else                bus_if.stb  = 1'b0;
      end
      if (started) begin
        got_tx.push_back(tx);
        got_bz.push_back(bus_if.busy);
        since++;
        // Change the divisor in the middle of the data bits of this frame.
        if ((n < q_b.size()) && (since == 3 * q_bc[n-1])) baud = q_d[n];
      end else if (tx) begin
        pre_hi++;
      end
      acc_next = bus_if.stb && !bus_if.busy && !brk;
    end

    chk({nm, " length"}, got_tx.size(), exp_tx.size());
    chk({nm, " accepts"}, n, q_b.size());
    bad = -1;
    for (int i = 0; i < got_tx.size(); i++) begin
      if (got_tx[i] !== exp_tx[i]) begin bad = i; break; end
    end
    chk({nm, " line first-bad-clk"}, bad, -1);
    bad = -1;
    for (int i = 0; i < got_bz.size(); i++) begin
      if (got_bz[i] !== exp_bz[i]) begin bad = i; break; end
    end
    chk({nm, " busy first-bad-clk"}, bad, -1);
    chk({nm, " idle after"}, int'(idle), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pre;
    int lowcnt;
    int nf;
    logic [W-1:0] d;

    rst_n = 1'b0; brk = 1'b0; baud = 24'd4;
    bus_if.stb = 1'b0; bus_if.data = 8'h00;
    #12;
    chk("reset tx",   int'(tx), 1);
    chk("reset busy", int'(bus_if.busy), 0);
    chk("reset idle", int'(idle), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-byte frames: {byte, requested divisor, expected clocks per bit}.
    vecs[0] = '{8'h55, 24'd4, 4};
    vecs[1] = '{8'hFF, 24'd0, 2};
    vecs[2] = '{8'h00, 24'd1, 2};
    vecs[3] = '{8'hA5, 24'd3, 3};
    vecs[4] = '{8'h81, 24'd2, 2};
    vecs[5] = '{8'h3C, 24'd7, 7};
    for (int i = 0; i < 6; i++) begin
      clear_frames();
      add_frame(vecs[i].data, vecs[i].div_in, vecs[i].exp_bit_clks);
      send_seq($sformatf("vec%0d", i), pre);
    end

    // Back-to-back: second start bit directly after first stop bit.
    clear_frames();
    add_frame(8'hA5, 24'd3, 3);
    add_frame(8'h80, 24'd3, 3);
    send_seq("b2b", pre);

    // Divisor change mid-frame only affects the following frame.
    clear_frames();
    add_frame(8'h96, 24'd4, 4);
    add_frame(8'h69, 24'd8, 8);
    send_seq("divchg", pre);

    // Reset in the middle of data bit 3 of an all-zero byte.
    bus_if.stb = 1'b1; bus_if.data = 8'h00; baud = 24'd4;
    @(negedge clk);
    bus_if.stb = 1'b0;
    repeat (17) @(negedge clk);
    chk("midframe tx",   int'(tx), 0);
    chk("midframe busy", int'(bus_if.busy), 1);
    chk("midframe idle", int'(idle), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset tx",   int'(tx), 1);
    chk("async reset busy", int'(bus_if.busy), 0);
    chk("async reset idle", int'(idle), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_frames();
    add_frame(8'h5A, 24'd4, 4);
    send_seq("post-reset", pre);

    // Break with a byte pending: break wins, then one idle bit before 0x3C.
    brk = 1'b1; bus_if.stb = 1'b1; bus_if.data = 8'h3C; baud = 24'd4;
    lowcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (tx == 1'b0) lowcnt++;
    end
    chk("break line low clks", lowcnt, 6);
    chk("break busy", int'(bus_if.busy), 1);
    chk("break idle", int'(idle), 0);
    brk = 1'b0;
    clear_frames();
    add_frame(8'h3C, 24'd4, 4);
    send_seq("after-break", pre);
    chk("break release high clks", pre, 4);

    // Random bursts of back-to-back frames with random divisors.
    for (int it = 0; it < 8; it++) begin
      clear_frames();
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        d = W'($urandom_range(0, 6));
        add_frame(8'($urandom_range(0, 255)), d, eff_div(d));
      end
      send_seq($sformatf("rand%0d", it), pre);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
